reg_step_ctrl: RTL and testbench

Sequencing controller that owns the four 8-bit loop/pointer registers (r0–r3) and the 8-bit program counter, and time-shares the single register-arithmetic unit between them. It accepts one decoded register-arithmetic instruction at a time (INCR, DECR, JIZR, JNZR) and drives the arithmetic unit's operand and control inputs. It writes the returned result back to the selected register and/or PC, then advances the PC. It sits between the decode stage, which feeds it, and the arithmetic unit, which it both feeds and consumes.

---
 rtl/reg_step_ctrl.sv | 125 ++++++++++++
 tb/tb_reg_step_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_step_ctrl.sv
// Sequencing controller for the loop/pointer registers r0-r3 and the PC.
// Time-shares one external register-arithmetic unit across the REG and PCU steps.
module reg_step_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op,
  input  logic [1:0] rsel,
  input  logic [2:0] v,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_sel,
  output logic [7:0] rd_data,
  output logic [7:0] pc,
  output logic       done,
  output logic [7:0] ar_x,
  output logic [2:0] ar_v,
  output logic       ar_incr,
  output logic       ar_decr,
  output logic       ar_jizr,
  output logic       ar_jnzr,
  input  logic [7:0] ar_res
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REG  = 2'b01,
    PCU  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_INCR = 2'b00,
    OP_DECR = 2'b01,
    OP_JIZR = 2'b10,
    OP_JNZR = 2'b11
  } op_t;

  state_t     state, state_nxt;
  op_t        op_l;
  logic [1:0] rsel_l;
  logic [2:0] v_l;
  logic       zero_l;
  logic [7:0] r [4];

  logic       accept;
  logic       reg_we;
  logic       pc_we;
  logic       taken;

  assign rd_data = r[rd_sel];
  assign taken   = ((op_l == OP_JIZR) &&  zero_l) ||
                   ((op_l == OP_JNZR) && !zero_l);

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    accept    = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    ar_x      = '0;
    ar_v      = '0;
    ar_incr   = 1'b0;
    ar_decr   = 1'b0;
    ar_jizr   = 1'b0;
    ar_jnzr   = 1'b0;
    case (state)
      IDLE: begin
        // an external load owns this cycle, so no instruction is accepted
        op_ready = ~wr_en;
        if (op_valid && !wr_en) begin
          accept    = 1'b1;
          state_nxt = op[1] ? PCU : REG;
        end
      end
      REG: begin
        ar_x      = r[rsel_l];
        ar_incr   = (op_l == OP_INCR);
        ar_decr   = (op_l == OP_DECR);
        reg_we    = 1'b1;
        state_nxt = PCU;
      end
      PCU: begin
        ar_x  = pc;
        pc_we = 1'b1;
        if (taken) begin
          ar_v    = v_l;
          ar_jizr = (op_l == OP_JIZR);
          ar_jnzr = (op_l == OP_JNZR);
        end else begin
          ar_incr = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_l   <= OP_INCR;
      rsel_l <= '0;
      v_l    <= '0;
      zero_l <= 1'b0;
      pc     <= '0;
      done   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= pc_we;
      if (accept) begin
        op_l   <= op_t'(op);
        rsel_l <= rsel;
        v_l    <= v;
        zero_l <= (r[rsel] == 8'h00);
      end
      if ((state == IDLE) && wr_en) r[wr_sel] <= wr_data;
      if (reg_we) r[rsel_l] <= ar_res;
      if (pc_we)  pc <= ar_res;
    end
  end

endmodule

// File: tb/tb_reg_step_ctrl.sv
// Bench for reg_step_ctrl: table of instructions/loads with expected pc and
// register values, scoreboard queue matched against done pulses.
module tb_reg_step_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op;
  logic [1:0] rsel;
  logic [2:0] v;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [7:0] wr_data;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic [7:0] pc;
  logic       done;
  logic [7:0] ar_x;
  logic [2:0] ar_v;
  logic       ar_incr, ar_decr, ar_jizr, ar_jnzr;
  logic [7:0] ar_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_step_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .rsel(rsel), .v(v),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
    .pc(pc), .done(done),
    .ar_x(ar_x), .ar_v(ar_v),
    .ar_incr(ar_incr), .ar_decr(ar_decr), .ar_jizr(ar_jizr), .ar_jnzr(ar_jnzr),
    .ar_res(ar_res)
  );

  // external arithmetic unit
  always_comb begin
    ar_res = 8'h00;
    if (ar_incr)                ar_res = ar_x + 8'd1;
    else if (ar_decr)           ar_res = ar_x - 8'd1;
    else if (ar_jizr | ar_jnzr) ar_res = (ar_v == 3'd0) ? ar_x + 8'd16
                                                        : ar_x + {4'b0000, ar_v, 1'b0};
  end

  typedef struct {
    bit         ld;
    logic [1:0] op;
    logic [1:0] rsel;
    logic [2:0] v;
    logic [7:0] exp_pc;
    logic [7:0] exp_r;
  } vec_t;

  typedef struct {
    logic [7:0] exp_pc;
    logic [1:0] rsel;
    logic [7:0] exp_r;
    int         acc_cyc;
    int         lat;
  } sb_t;

  vec_t vec[$];
  vec_t pend[$];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit ld, logic [1:0] o, logic [1:0] s, logic [2:0] vv,
                              logic [7:0] epc, logic [7:0] er);
    vec_t t;
    t.ld = ld; t.op = o; t.rsel = s; t.v = vv; t.exp_pc = epc; t.exp_r = er;
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0({ar_incr, ar_decr, ar_jizr, ar_jnzr}) ||
          (({ar_incr, ar_decr, ar_jizr, ar_jnzr} == 4'b0000) && ((ar_x != 8'h00) || (ar_v != 3'd0)))) begin
        errors++;
        $display("FAIL ar_ctrl: got ctl=%b x=0x%0h v=%0d, expected one-hot/zero ctl and x=0,v=0 when idle",
                 {ar_incr, ar_decr, ar_jizr, ar_jnzr}, ar_x, ar_v);
      end
    end
  end

  task automatic present(input vec_t t);
    op_valid = 1'b1;
    op       = t.op;
    rsel     = t.rsel;
    v        = t.v;
  endtask

  // Drains pend; b2b keeps op_valid high and expects each accept on a done cycle.
  task automatic run_pending(input bit b2b);
    vec_t cur;
    sb_t  e;
    bit   accepted;
    bit   finished = 1'b0;
    int   nacc = 0;
    @(posedge clk); #1;
    cur = pend.pop_front();
    present(cur);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done), 32'(0));
        end else begin
          e = sb.pop_front();
          rd_sel = e.rsel;
          #1;
          chk("pc_at_done", 32'(pc), 32'(e.exp_pc));
          chk("reg_at_done", 32'(rd_data), 32'(e.exp_r));
          chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
      accepted = op_valid && op_ready;
      if (accepted) begin
        if (b2b && nacc > 0) chk("b2b_accept_on_done", 32'(done), 32'(1));
        e.exp_pc = cur.exp_pc; e.rsel = cur.rsel; e.exp_r = cur.exp_r;
        e.acc_cyc = cyc; e.lat = cur.op[1] ? 2 : 3;
        sb.push_back(e);
        nacc++;
      end
      if (!op_valid && sb.size() == 0) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (b2b && pend.size() > 0) begin
          cur = pend.pop_front();
          present(cur);
        end else begin
          op_valid = 1'b0;
          op   = 2'($urandom);
          rsel = 2'($urandom);
          v    = 3'($urandom);
        end
      end
    end
    if (!finished) begin
      chk("stream_timeout", 32'(0), 32'(1));
      op_valid = 1'b0;
      sb.delete();
      pend.delete();
    end
  endtask

  task automatic do_load(input logic [1:0] s, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_sel = s; wr_data = d;
    @(negedge clk);
    chk("ready_low_on_load", 32'(op_ready), 32'(0));
    @(posedge clk); #1;
    wr_en = 1'b0;
    rd_sel = s;
    @(negedge clk);
    chk("load_value", 32'(rd_data), 32'(d));
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = '0; rsel = '0; v = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;

    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(op_ready), 32'(1));
    chk("rst_ar", 32'({ar_incr, ar_decr, ar_jizr, ar_jnzr, ar_x}), 32'(0));
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk("rst_reg", 32'(rd_data), 32'(0));
    end
    rst_n = 1'b1;

    vec.push_back(mk(0, 2'b00, 2'd1, 3'd0, 8'h01, 8'h01));
    vec.push_back(mk(0, 2'b00, 2'd1, 3'd0, 8'h02, 8'h02));
    vec.push_back(mk(0, 2'b00, 2'd1, 3'd0, 8'h03, 8'h03));
    vec.push_back(mk(1, 2'b00, 2'd2, 3'd0, 8'h03, 8'h00));
    vec.push_back(mk(0, 2'b01, 2'd2, 3'd0, 8'h04, 8'hFF));
    vec.push_back(mk(0, 2'b10, 2'd0, 3'd6, 8'h10, 8'h00));
    vec.push_back(mk(0, 2'b10, 2'd0, 3'd3, 8'h16, 8'h00));
    vec.push_back(mk(0, 2'b11, 2'd0, 3'd3, 8'h17, 8'h00));
    vec.push_back(mk(1, 2'b00, 2'd3, 3'd0, 8'h17, 8'h05));
    for (int i = 1; i <= 14; i++)
      vec.push_back(mk(0, 2'b11, 2'd3, 3'd0, 8'(8'h17 + 16 * i), 8'h05));
    vec.push_back(mk(0, 2'b10, 2'd3, 3'd2, 8'hF8, 8'h05));
    vec.push_back(mk(0, 2'b10, 2'd3, 3'd2, 8'hF9, 8'h05));
    vec.push_back(mk(0, 2'b10, 2'd3, 3'd2, 8'hFA, 8'h05));
    vec.push_back(mk(0, 2'b11, 2'd3, 3'd0, 8'h0A, 8'h05));
    vec.push_back(mk(0, 2'b10, 2'd3, 3'd5, 8'h0B, 8'h05));
    vec.push_back(mk(0, 2'b01, 2'd3, 3'd0, 8'h0C, 8'h04));
    vec.push_back(mk(1, 2'b00, 2'd0, 3'd0, 8'h0C, 8'hFF));
    vec.push_back(mk(0, 2'b00, 2'd0, 3'd0, 8'h0D, 8'h00));

    foreach (vec[i]) begin
      if (vec[i].ld) begin
        do_load(vec[i].rsel, vec[i].exp_r);
      end else begin
        pend.push_back(vec[i]);
        run_pending(1'b0);
      end
    end

    // load and instruction offered together: the load wins, nothing accepted
    @(posedge clk); #1;
    op_valid = 1'b1; op = 2'b00; rsel = 2'd1;
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h5A;
    @(negedge clk);
    chk("collide_ready", 32'(op_ready), 32'(0));
    @(posedge clk); #1;
    wr_en = 1'b0; op_valid = 1'b0; rd_sel = 2'd2;
    @(negedge clk);
    chk("collide_load", 32'(rd_data), 32'(8'h5A));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("collide_no_done", 32'(done), 32'(0));
    end
    chk("collide_pc", 32'(pc), 32'(8'h0D));
    rd_sel = 2'd1;
    #1;
    chk("collide_r1", 32'(rd_data), 32'(8'h03));

    pend.push_back(mk(0, 2'b00, 2'd1, 3'd0, 8'h0E, 8'h04));
    pend.push_back(mk(0, 2'b10, 2'd0, 3'd1, 8'h10, 8'h00));
    pend.push_back(mk(0, 2'b01, 2'd1, 3'd0, 8'h11, 8'h03));
    run_pending(1'b1);

    // reset during the REG cycle of INCR r1
    do_load(2'd1, 8'h07);
    @(posedge clk); #1;
    op_valid = 1'b1; op = 2'b00; rsel = 2'd1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("abort_in_reg", 32'(ar_incr), 32'(1));
    rst_n = 1'b0; rd_sel = 2'd1;
    #1;
    chk("abort_pc", 32'(pc), 32'(0));
    chk("abort_r1", 32'(rd_data), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_ready", 32'(op_ready), 32'(1));
    chk("abort_ar", 32'({ar_incr, ar_decr, ar_jizr, ar_jnzr}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pend.push_back(mk(0, 2'b00, 2'd1, 3'd0, 8'h01, 8'h01));
    run_pending(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
